muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit holding the architectural HI/LO registers. Sits directly downstream of `registerfile`: its `outputA` (rs) and `outputB` (rt) values feed operands `a`/`b`. It executes MULT, MULTU, DIV, DIVU in a fixed WIDTH+2 cycles and MTHI/MTLO in one cycle. It exposes `busy`/`done` so decode can stall MFHI/MFLO and further mul/div issue.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 47 ++++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide unit.
//   - operation codes carried on the 3-bit op port
//   - FSM state encoding
//   - quotient forced on divide-by-zero
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Widest datapath the package constants cover; the top slices what it needs.
  localparam int MAX_WIDTH = 64;

  // LO value written when a divide sees a zero divisor.
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration shared by multiply and divide.
// Ports:
//   mode_div  in  1      0 = shift-add multiply step, 1 = restoring divide step
//   acc_i     in  WIDTH  upper half (partial product / partial remainder)
//   low_i     in  WIDTH  lower half (multiplier bits / dividend bits -> quotient)
//   operand_i in  WIDTH  multiplicand or divisor magnitude
//   acc_o     out WIDTH  next upper half
//   low_o     out WIDTH  next lower half
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] low_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] low_o
);

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier LSB is set,
    // then shift the {carry, acc, low} pair right by one. After WIDTH steps
    // {acc, low} holds the full product.
    mul_sum   = {1'b0, acc_i} + (low_i[0] ? {1'b0, operand_i} : '0);

    // Divide: bring the next dividend bit into the partial remainder, then
    // subtract the divisor if it fits. Quotient bits enter low from the right
    // as the dividend bits leave from the left.
    div_shift = {acc_i, low_i[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, operand_i});
    div_diff  = div_shift - {1'b0, operand_i};

    if (mode_div) begin
      acc_o = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      low_o = {low_i[WIDTH-2:0], div_ge};
    end else begin
      acc_o = mul_sum[WIDTH:1];
      low_o = {mul_sum[0], low_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Mul/div take WIDTH+2 cycles (accept, WIDTH iterations, sign fix); MTHI/MTLO
// write in one cycle. Requests are only sampled while idle.
// Ports:
//   clock  in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset
//   start  in  1      request strobe (ignored while busy)
//   op     in  3      operation code (see muldiv_pkg)
//   a      in  WIDTH  rs: dividend / multiplicand / MTHI-MTLO source
//   b      in  WIDTH  rt: divisor / multiplier
//   hi     out WIDTH  HI register
//   lo     out WIDTH  LO register
//   busy   out 1      operation in flight
//   done   out 1      one-cycle pulse when a mul/div result lands in HI/LO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   low_q, low_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               div0_q, div0_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   acc_step, low_step;
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div  (is_div_q),
    .acc_i     (acc_q),
    .low_i     (low_q),
    .operand_i (opnd_q),
    .acc_o     (acc_step),
    .low_o     (low_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    low_d     = low_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    div0_d    = div0_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;

    // Magnitudes: -(most negative) wraps to itself, which is exactly the
    // unsigned magnitude, so the overflow divide needs no special case.
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    prod      = {acc_q, low_q};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op <= OP_DIVU) begin
            // Both modes start with a in low and b as the operand.
            state_d   = ST_CALC;
            cnt_d     = '0;
            acc_d     = '0;
            low_d     = a_mag;
            opnd_d    = b_mag;
            is_div_d  = (op == OP_DIV) || (op == OP_DIVU);
            div0_d    = (b == '0);
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end

      ST_CALC: begin
        acc_d = acc_step;
        low_d = low_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        if (is_div_q) begin
          // With a zero divisor every trial subtract succeeds, so the
          // remainder register ends holding |a|; restoring a's sign gives a.
          hi_d = neg_rem_q ? -acc_q : acc_q;
          if (div0_q) begin
            lo_d = DIV0_QUOTIENT[WIDTH-1:0];
          end else begin
            lo_d = neg_res_q ? -low_q : low_q;
          end
        end else begin
          if (neg_res_q) begin
            prod = -prod;
          end
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      div0_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      low_q     <= low_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      div0_q    <= div0_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32).
// The driver pushes the reference result of each accepted mul/div into a
// queue; a negedge monitor pops and compares whenever done is seen.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           e0;
  } exp_t;

  exp_t         sb_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [W-1:0] av,
                                            input logic [W-1:0] bv);
    longint sa, sb, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    ref_model = '0;
    case (o)
      3'd0: begin
        q = sa * sb;
        ref_model = q[63:0];
      end
      3'd1: begin
        up = ua * ub;
        ref_model = up[63:0];
      end
      3'd2: begin
        if (bv == '0) ref_model = {av, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_model = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (bv == '0) ref_model = {av, 32'hFFFF_FFFF};
        else begin
          up = ua / ub;
          ref_model[31:0] = up[31:0];
          up = ua % ub;
          ref_model[63:32] = up[31:0];
        end
      end
      default: ref_model = '0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expected result and
  // arrive WIDTH+1 edges after the accepting edge.
  always @(negedge clock) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, e.hi});
        check("result_lo", {32'd0, lo}, {32'd0, e.lo});
        check("latency", 64'(cyc - e.e0), 64'(W + 1));
        check("busy_at_done", {63'd0, busy}, 64'd0);
        $display("result op done: hi=0x%08h lo=0x%08h", hi, lo);
        model_hi = e.hi;
        model_lo = e.lo;
      end
    end
  end

  // Wait for idle (bounded), present one request for one edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    logic [63:0] r;
    exp_t e;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busy && n < 200);
    if (busy) check("issue_timeout", {63'd0, busy}, 64'd0);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clock);
    #1;
    start = 1'b0;
    $display("issue op=%0d a=0x%08h b=0x%08h at cycle %0d", o, av, bv, cyc);
    if (o <= 3'd3) begin
      r    = ref_model(o, av, bv);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.e0 = cyc;
      sb_q.push_back(e);
    end else if (o == 3'd4) begin
      model_hi = av;
    end else if (o == 3'd5) begin
      model_lo = av;
    end
  endtask

  task automatic check_idle_regs(input string tag);
    @(negedge clock);
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, model_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, model_lo});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int           sel;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    // Directed corner cases, issued back-to-back in each done cycle.
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);
    issue(3'd3, 32'd7, 32'd2);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd3, 32'd100, 32'd0);
    issue(3'd2, 32'hFFFF_FFFB, 32'd0);

    // MTHI while idle, then a reserved op that must do nothing.
    issue(3'd4, 32'h1234_5678, 32'd0);
    check_idle_regs("mthi");
    issue(3'd6, 32'hAAAA_5555, 32'd1);
    check_idle_regs("reserved_op");

    // MULTU 3x4 with MTLO and DIV attempted mid-calculation.
    issue(3'd1, 32'd3, 32'd4);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 3'd5; a = 32'h0000_DEAD; b = 32'd0;
    @(posedge clock); #1; start = 1'b0;
    @(negedge clock);
    check("midcalc_hi_hold", {32'd0, hi}, {32'd0, model_hi});
    check("midcalc_lo_hold", {32'd0, lo}, {32'd0, model_lo});
    check("midcalc_busy", {63'd0, busy}, 64'd1);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(posedge clock); #1; start = 1'b0;

    // Reset during CALC discards the result.
    issue(3'd1, 32'd5, 32'd5);
    repeat (10) @(negedge clock);
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    sb_q.delete();
    model_hi = '0;
    model_lo = '0;
    check_idle_regs("midcalc_reset");
    repeat (40) @(negedge clock);
    issue(3'd1, 32'd5, 32'd5);

    // Randomized mix with operand corners.
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      ra  = $urandom;
      rb  = $urandom;
      if (sel < 8) begin
        ro = 3'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
          0: rb = '0;
          1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
          2: begin ra = ra & 32'hFF; rb = rb & 32'hF; end
          3: rb = rb & 32'hFFFF;
          default: ;
        endcase
        issue(ro, ra, rb);
      end else begin
        ro = (sel == 8) ? 3'd4 : 3'd5;
        issue(ro, ra, rb);
        check_idle_regs("rand_mt");
      end
    end

    // Drain the scoreboard within a bounded wait.
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_pending", 64'(sb_q.size()), 64'd0);
    repeat (5) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
